// File: rtl/imem_pipe.sv
// Instruction memory with a fixed READ_LAT fetch pipeline, one request outstanding, response held until taken.
// Define IMEM_LOAD_EN to add the ld_* program-load write port (it stalls fetch while ld_we is high).
module imem_pipe #(
   parameter int    DATA_W    = 32,
   parameter int    DEPTH     = 1024,
   parameter int    READ_LAT  = 1,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [31:0]       req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_instr,
   output logic              resp_err
`ifdef IMEM_LOAD_EN
   ,
   input  logic              ld_we,
   input  logic [31:0]       ld_addr,
   input  logic [DATA_W-1:0] ld_data
`endif
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;
   logic              load_busy;
   logic              req_err;
   logic [AW-1:0]     req_idx;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   assign req_idx = req_addr[AW+1:2];
   assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);

`ifdef IMEM_LOAD_EN
   logic [AW-1:0] ld_idx;
   logic          ld_ok;

   assign ld_idx    = ld_addr[AW+1:2];
   assign ld_ok     = ld_we && (ld_addr[1:0] == 2'b00) && !(|ld_addr[31:AW+2]);
   assign load_busy = ld_we;

   // Non-blocking write: a fetch captured on the same edge still sees the old word.
   always_ff @(posedge clk) begin
      if (ld_ok) mem[ld_idx] <= ld_data;
   end
`else
   assign load_busy = 1'b0;
`endif

   assign resp_valid = (state == HOLD);

   always_comb begin
      req_ready = !load_busy && ((state == IDLE) || ((state == HOLD) && resp_ready));
      accept    = req_valid && req_ready;
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: state_nxt = IDLE;
         WAIT: begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1) state_nxt = HOLD;
         end
         HOLD: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A new accept overrides the HOLD->IDLE exit so back-to-back fetches have no bubble.
      if (accept) begin
         if (READ_LAT == 1) begin
            state_nxt = HOLD;
         end else begin
            state_nxt = WAIT;
            cnt_nxt   = 2'(READ_LAT - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_instr <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            resp_err   <= req_err;
            resp_instr <= req_err ? '0 : mem[req_idx];
         end
      end
   end

endmodule

// File: tb/tb_imem_pipe.sv
// Three imem_pipe instances (READ_LAT 1..3), each with a random+directed driver and a scoreboard monitor.
// The reference model is a plain word array plus a queue of expected responses stamped with their due cycle.
module tb_imem_pipe;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      int          ready_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, want, $time);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int LAT = g + 1;

      logic        rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_err;
      logic [31:0] req_addr, resp_instr;
      logic        ld_busy;
      logic        last_acc;
      logic        done = 1'b0;
      logic [31:0] ref_mem [DEPTH];
      exp_t        q [$];

`ifdef IMEM_LOAD_EN
      logic        ld_we;
      logic [31:0] ld_addr, ld_data;
      assign ld_busy = ld_we;
`else
      assign ld_busy = 1'b0;
`endif

      imem_pipe #(.DATA_W(32), .DEPTH(DEPTH), .READ_LAT(LAT), .INIT_FILE("")) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req_valid  (req_valid),
         .req_addr   (req_addr),
         .req_ready  (req_ready),
         .resp_valid (resp_valid),
         .resp_ready (resp_ready),
         .resp_instr (resp_instr),
         .resp_err   (resp_err)
`ifdef IMEM_LOAD_EN
         ,
         .ld_we      (ld_we),
         .ld_addr    (ld_addr),
         .ld_data    (ld_data)
`endif
      );

      function automatic exp_t expect_for(logic [31:0] a, int c);
         exp_t e;
         e.err   = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
         e.instr = 32'h0;
         if (!e.err) e.instr = ref_mem[int'(a >> 2)];
         e.ready_cyc = c + LAT;
         return e;
      endfunction

      // Inputs are set at posedge+1; the accept decision is visible from negedge onwards.
      task automatic tick();
         @(negedge clk);
         #1;
         last_acc = rst_n && req_valid && req_ready;
         if (last_acc) q.push_back(expect_for(req_addr, cyc));
`ifdef IMEM_LOAD_EN
         if (ld_we && (ld_addr[1:0] == 2'b00) && (ld_addr < 32'(4 * DEPTH)))
            ref_mem[int'(ld_addr >> 2)] = ld_data;
`endif
         @(posedge clk);
         #1;
      endtask

      task automatic issue(logic [31:0] a, logic rr);
         int n;
         req_valid  = 1'b1;
         req_addr   = a;
         resp_ready = rr;
         n = 0;
         last_acc = 1'b0;
         while (!last_acc && n < 30) begin
            tick();
            n++;
         end
         req_valid = 1'b0;
         if (!last_acc) chk($sformatf("L%0d issue_timeout", LAT), 32'(last_acc), 32'd1);
      endtask

      task automatic drain();
         req_valid  = 1'b0;
         resp_ready = 1'b1;
         repeat (LAT + 3) tick();
      endtask

      // Scoreboard monitor
      initial begin
         logic exp_v;
         forever begin
            @(negedge clk);
            if (!rst_n) continue;
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (cyc >= q[0].ready_cyc);
            chk($sformatf("L%0d resp_valid", LAT), 32'(resp_valid), 32'(exp_v));
            if (exp_v && resp_valid) begin
               chk($sformatf("L%0d resp_instr", LAT), resp_instr, q[0].instr);
               chk($sformatf("L%0d resp_err", LAT), 32'(resp_err), 32'(q[0].err));
            end
            chk($sformatf("L%0d req_ready", LAT), 32'(req_ready),
                32'(!ld_busy && ((q.size() == 0) || (exp_v && resp_ready))));
            if (resp_valid && resp_ready && q.size() > 0) void'(q.pop_front());
         end
      end

      // Driver
      initial begin
         logic [31:0] w;
         logic [31:0] a;
         rst_n      = 1'b0;
         req_valid  = 1'b0;
         req_addr   = 32'h0;
         resp_ready = 1'b0;
`ifdef IMEM_LOAD_EN
         ld_we   = 1'b0;
         ld_addr = 32'h0;
         ld_data = 32'h0;
`endif
         #3;
         chk($sformatf("L%0d rst_resp_valid", LAT), 32'(resp_valid), 32'd0);
         chk($sformatf("L%0d rst_resp_instr", LAT), resp_instr, 32'd0);
         chk($sformatf("L%0d rst_resp_err", LAT), 32'(resp_err), 32'd0);
         chk($sformatf("L%0d rst_req_ready", LAT), 32'(req_ready), 32'd1);
         for (int i = 0; i < DEPTH; i++) begin
            case (i)
               0:       w = 32'h20020005;
               1:       w = 32'h20030003;
               4:       w = 32'hDEADBEEF;
               default: w = $urandom | 32'h1;
            endcase
            ref_mem[i] = w;
`ifndef IMEM_LOAD_EN
            u_dut.mem[i] = w;
`endif
         end
         #9 rst_n = 1'b1;
         @(posedge clk);
         #1;
`ifdef IMEM_LOAD_EN
         // Program the image through the load port; the model picks it up in tick().
         for (int i = 0; i < DEPTH; i++) begin
            ld_we   = 1'b1;
            ld_addr = 32'(i * 4);
            ld_data = ref_mem[i];
            ref_mem[i] = 32'h0;
            tick();
         end
         ld_we = 1'b0;
`endif
         issue(32'h0, 1'b1);
         issue(32'h4, 1'b1);
         issue(32'h10, 1'b1);
         issue(32'h6, 1'b1);
         issue(32'(4 * DEPTH), 1'b1);
         drain();
         issue(32'h8, 1'b0);
         repeat (4) tick();
         drain();
`ifdef IMEM_LOAD_EN
         // Load and fetch of word 0 presented together: fetch must wait, then see the new word.
         ld_we      = 1'b1;
         ld_addr    = 32'h0;
         ld_data    = 32'h12345678;
         req_valid  = 1'b1;
         req_addr   = 32'h0;
         tick();
         chk($sformatf("L%0d fetch_during_load", LAT), 32'(last_acc), 32'd0);
         ld_we = 1'b0;
         issue(32'h0, 1'b1);
         drain();
`endif
         // Reset with a request in flight
         issue(32'h8, 1'b0);
         rst_n = 1'b0;
         #1;
         chk($sformatf("L%0d midrst_resp_valid", LAT), 32'(resp_valid), 32'd0);
         chk($sformatf("L%0d midrst_resp_instr", LAT), resp_instr, 32'd0);
         chk($sformatf("L%0d midrst_resp_err", LAT), 32'(resp_err), 32'd0);
         q.delete();
         @(negedge clk);
         #2 rst_n = 1'b1;
         #1;
         chk($sformatf("L%0d postrst_req_ready", LAT), 32'(req_ready), 32'd1);
         @(posedge clk);
         #1;
         resp_ready = 1'b1;
         repeat (LAT + 2) tick();

         for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            case ($urandom_range(0, 7))
               0:       a = a | 32'($urandom_range(1, 3));
               1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
               2:       a = $urandom;
               default: a = a;
            endcase
            req_addr = a;
`ifdef IMEM_LOAD_EN
            ld_we   = ($urandom_range(0, 7) == 0);
            ld_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            ld_data = $urandom;
`endif
            tick();
         end
`ifdef IMEM_LOAD_EN
         ld_we = 1'b0;
`endif
         drain();
         chk($sformatf("L%0d drained", LAT), 32'(q.size()), 32'd0);
         done = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(lane[0].done && lane[1].done && lane[2].done) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      chk("all_lanes_done", 32'(lane[0].done && lane[1].done && lane[2].done), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
